// File: rtl/rx_buf_pkg.sv
// Shared constants and types for the receive buffer controller.
package rx_buf_pkg;

    localparam int unsigned AddrWDefault = 10;

    localparam logic [4:0] RegCtrl   = 5'h00;
    localparam logic [4:0] RegStatus = 5'h04;
    localparam logic [4:0] RegLen    = 5'h08;
    localparam logic [4:0] RegData   = 5'h0C;
    localparam logic [4:0] RegPop    = 5'h10;

    typedef enum logic [1:0] {StIdle, StReq, StWait, StAck} rd_state_e;

endpackage

// File: rtl/rx_buf_ctrl_if.sv
// Wishbone slave bus bundle for the receive buffer controller.
interface rx_buf_ctrl_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/rx_len_fifo.sv
// Queue of completed frame lengths; head entry is the frame currently exposed to software.
module rx_len_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 11
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic [Width-1:0]             data_i,
    input  logic                         pop_i,
    output logic [Width-1:0]             data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(Depth+1)-1:0]   count_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_q, rd_q;
    logic [CntW-1:0]  cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q <= (wr_q == PtrW'(Depth - 1)) ? '0 : wr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_q <= (rd_q == PtrW'(Depth - 1)) ? '0 : rd_q + PtrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CntW'(1);
                2'b01:   cnt_q <= cnt_q - CntW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/rx_buf_ctrl.sv
// Receive frame buffer: byte ring in external SRAM, frame length queue, Wishbone register file.
// Optional RX_BUF_FCS_STRIP_EN hides the trailing 4-byte FCS from LEN and DATA.
module rx_buf_ctrl
    import rx_buf_pkg::*;
#(
    parameter int unsigned LEN_FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W         = AddrWDefault
) (
    input  logic              wb_clk_i,
    input  logic              rst_n,
    input  logic              rx_vld,
    input  logic [7:0]        rx_data,
    input  logic              rx_last,
    input  logic              rx_err,
    output logic              mem_csb,
    output logic              mem_web,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    input  logic [7:0]        mem_dout,
    rx_buf_ctrl_if.slave      wb,
    output logic              rx_irq
);
    localparam int unsigned PW = ADDR_W + 1;
    localparam int unsigned CW = $clog2(LEN_FIFO_DEPTH + 1);
    localparam logic [PW-1:0] RingSize = {1'b1, {ADDR_W{1'b0}}};

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, frame_start_q, frame_start_d;
    logic [PW-1:0] rd_base_q, rd_base_d, rd_ptr_q, rd_ptr_d;
    logic          dropping_q, dropping_d, sync_q, sync_d;
    logic          en_q, en_d, irq_en_q, irq_en_d, ovf_q, ovf_d, irq_q;
    logic          ack_q, ack_d;
    logic [31:0]   dat_q, dat_d;
    rd_state_e     state_q, state_d;

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [PW-1:0] fifo_head, wr_inc, used, len_stored, len_rep, rd_off;
    logic [CW-1:0] fifo_count;
    logic          ring_full, byte_first, wr_en, rd_en, set_ovf, rd_ok, new_req;
    logic [4:0]    reg_adr;
    logic          unused_bits;

    rx_len_fifo #(
        .Depth (LEN_FIFO_DEPTH),
        .Width (PW)
    ) u_len_fifo (
        .clk_i   (wb_clk_i),
        .rst_ni  (rst_n),
        .push_i  (fifo_push),
        .data_i  (wr_inc - frame_start_q),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Extra pointer bit keeps a full ring (RingSize bytes) distinct from an empty one.
    assign used       = wr_ptr_q - rd_base_q;
    assign ring_full  = (used == RingSize);
    assign wr_inc     = wr_ptr_q + PW'(1);
    assign byte_first = (wr_ptr_q == frame_start_q);
    assign len_stored = fifo_empty ? '0 : fifo_head;
`ifdef RX_BUF_FCS_STRIP_EN
    assign len_rep    = (len_stored < PW'(4)) ? '0 : len_stored - PW'(4);
`else
    assign len_rep    = len_stored;
`endif
    assign rd_off     = rd_ptr_q - rd_base_q;
    assign rd_ok      = !fifo_empty && (rd_off < len_rep);
    assign reg_adr    = wb.wbs_adr_i[4:0];
    assign new_req    = wb.wbs_stb_i && wb.wbs_cyc_i && !ack_q && (state_q == StIdle);
    assign unused_bits = ^{wb.wbs_adr_i[31:5], wb.wbs_dat_i[31:9], wb.wbs_dat_i[7:2]};

    // Byte ingest. sync_q stays low after reset until the stream is seen idle or ends a
    // frame, so a frame already running at reset release is dropped rather than stored.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        frame_start_d = frame_start_q;
        dropping_d    = dropping_q;
        sync_d        = sync_q;
        wr_en         = 1'b0;
        fifo_push     = 1'b0;
        set_ovf       = 1'b0;
        if (!rx_vld || rx_last) sync_d = 1'b1;
        if (rx_vld) begin
            if (dropping_q || !sync_q) begin
                dropping_d = !rx_last;
            end else if (!en_q || ring_full || (byte_first && fifo_full) || rx_err) begin
                wr_ptr_d   = frame_start_q;
                dropping_d = !rx_last;
                set_ovf    = en_q;
            end else begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_inc;
                if (rx_last) begin
                    fifo_push     = 1'b1;
                    frame_start_d = wr_inc;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ack_d     = 1'b0;
        dat_d     = dat_q;
        rd_ptr_d  = rd_ptr_q;
        rd_base_d = rd_base_q;
        en_d      = en_q;
        irq_en_d  = irq_en_q;
        ovf_d     = ovf_q | set_ovf;
        fifo_pop  = 1'b0;
        rd_en     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (new_req) begin
                    if (!wb.wbs_we_i && reg_adr == RegData && rd_ok) begin
                        state_d = StReq;
                    end else begin
                        ack_d = 1'b1;
                        dat_d = '0;
                        if (wb.wbs_we_i) begin
                            case (reg_adr)
                                RegCtrl:   {irq_en_d, en_d} = wb.wbs_dat_i[1:0];
                                RegStatus: if (wb.wbs_dat_i[8]) ovf_d = set_ovf;
                                RegPop: begin
                                    if (!fifo_empty) begin
                                        fifo_pop  = 1'b1;
                                        rd_base_d = rd_base_q + fifo_head;
                                        rd_ptr_d  = rd_base_q + fifo_head;
                                    end
                                end
                                default: ;
                            endcase
                        end else begin
                            case (reg_adr)
                                RegCtrl:   dat_d[1:0] = {irq_en_q, en_q};
                                RegStatus: begin
                                    dat_d[8]   = ovf_q;
                                    dat_d[3:0] = 4'(fifo_count);
                                end
                                RegLen:    dat_d = 32'(len_rep);
                                default: ;
                            endcase
                        end
                    end
                end
            end
            // Incoming bytes own the single SRAM port; the read waits for an idle cycle.
            StReq: begin
                if (!rx_vld) begin
                    rd_en   = 1'b1;
                    state_d = StWait;
                end
            end
            StWait: begin
                ack_d   = 1'b1;
                dat_d   = {24'h0, mem_dout};
                state_d = StAck;
            end
            StAck: begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                state_d  = StIdle;
            end
        endcase
    end

    always_comb begin
        mem_csb  = !(wr_en || rd_en);
        mem_web  = !wr_en;
        mem_addr = wr_en ? wr_ptr_q[ADDR_W-1:0] : (rd_en ? rd_ptr_q[ADDR_W-1:0] : '0);
        mem_din  = wr_en ? rx_data : 8'h00;
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            frame_start_q <= '0;
            rd_base_q     <= '0;
            rd_ptr_q      <= '0;
            dropping_q    <= 1'b0;
            sync_q        <= 1'b0;
            en_q          <= 1'b0;
            irq_en_q      <= 1'b0;
            ovf_q         <= 1'b0;
            irq_q         <= 1'b0;
            ack_q         <= 1'b0;
            dat_q         <= '0;
            state_q       <= StIdle;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            frame_start_q <= frame_start_d;
            rd_base_q     <= rd_base_d;
            rd_ptr_q      <= rd_ptr_d;
            dropping_q    <= dropping_d;
            sync_q        <= sync_d;
            en_q          <= en_d;
            irq_en_q      <= irq_en_d;
            ovf_q         <= ovf_d;
            irq_q         <= irq_en_q && (fifo_count != '0);
            ack_q         <= ack_d;
            dat_q         <= dat_d;
            state_q       <= state_d;
        end
    end

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = dat_q;
    assign rx_irq       = irq_q;

endmodule

// File: tb/tb_rx_buf_ctrl.sv
// Directed bench for rx_buf_ctrl with a behavioural 1-cycle-latency SRAM.
module tb_rx_buf_ctrl;
    import rx_buf_pkg::*;

`ifdef RX_BUF_FCS_STRIP_EN
    localparam int Fcs = 4;
`else
    localparam int Fcs = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_vld, rx_last, rx_err;
    logic [7:0]  rx_data;
    logic        mem_csb, mem_web;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_din, mem_dout;
    logic        rx_irq;
    logic [7:0]  sram [1024];
    int          n_checks = 0;
    int          n_errors = 0;
    int          lat;
    logic [31:0] rdat;
    bit          got;

    rx_buf_ctrl_if wb ();

    rx_buf_ctrl dut (
        .wb_clk_i (clk),
        .rst_n    (rst_n),
        .rx_vld   (rx_vld),
        .rx_data  (rx_data),
        .rx_last  (rx_last),
        .rx_err   (rx_err),
        .mem_csb  (mem_csb),
        .mem_web  (mem_web),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .wb       (wb),
        .rx_irq   (rx_irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!mem_csb) begin
            if (!mem_web) sram[mem_addr] <= mem_din;
            else          mem_dout <= sram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_byte(input logic [7:0] seed, input int i, input int len);
        logic [7:0] b;
        b = seed + 8'(i);
        return (i < len - Fcs) ? {24'h0, b} : 32'h0;
    endfunction

    function automatic logic [31:0] exp_len(input int len);
        return (len < Fcs) ? 32'h0 : 32'(len - Fcs);
    endfunction

    // exp_addr >= 0: first byte must hit SRAM there; -2: first byte must be refused; -1: skip.
    task automatic send_frame(input int len, input logic [7:0] seed, input int err_at,
                              input int exp_addr);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            rx_vld  = 1'b1;
            rx_data = seed + 8'(i);
            rx_last = (i == len - 1);
            rx_err  = (i == err_at);
            if (i == 0 && exp_addr != -1) begin
                #1;
                if (exp_addr >= 0) begin
                    check("wr_csb", {31'h0, mem_csb}, 32'h0);
                    check("wr_web", {31'h0, mem_web}, 32'h0);
                    check("wr_addr", {22'h0, mem_addr}, exp_addr);
                end else begin
                    check("drop_csb", {31'h0, mem_csb}, 32'h1);
                end
            end
        end
        @(negedge clk);
        rx_vld = 1'b0; rx_last = 1'b0; rx_err = 1'b0;
    endtask

    task automatic xfer(input logic we, input logic [4:0] adr, input logic [31:0] wdat,
                        output logic [31:0] rd);
        bit ok = 1'b0;
        @(negedge clk);
        wb.wbs_stb_i = 1'b1; wb.wbs_cyc_i = 1'b1; wb.wbs_we_i = we;
        wb.wbs_adr_i = {27'h0, adr}; wb.wbs_dat_i = wdat;
        rd = '0;
        lat = 0;
        for (int k = 0; k < 64 && !ok; k++) begin
            @(negedge clk);
            if (wb.wbs_ack_o) begin ok = 1'b1; rd = wb.wbs_dat_o; lat = k + 1; end
        end
        wb.wbs_stb_i = 1'b0; wb.wbs_cyc_i = 1'b0; wb.wbs_we_i = 1'b0;
        check("ack_seen", {31'h0, ok}, 32'h1);
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] adr, input logic [31:0] exp);
        logic [31:0] d;
        xfer(1'b0, adr, 32'h0, d);
        check(tag, d, exp);
    endtask

    task automatic wr(input logic [4:0] adr, input logic [31:0] d);
        logic [31:0] dummy;
        xfer(1'b1, adr, d, dummy);
    endtask

    initial begin
        rst_n = 1'b0; rx_vld = 1'b1; rx_data = 8'h5A; rx_last = 1'b0; rx_err = 1'b0;
        wb.wbs_stb_i = 1'b0; wb.wbs_cyc_i = 1'b0; wb.wbs_we_i = 1'b0;
        wb.wbs_adr_i = '0; wb.wbs_dat_i = '0;
        #3;
        check("rst_csb", {31'h0, mem_csb}, 32'h1);
        check("rst_web", {31'h0, mem_web}, 32'h1);
        check("rst_addr", {22'h0, mem_addr}, 32'h0);
        check("rst_din", {24'h0, mem_din}, 32'h0);
        check("rst_ack", {31'h0, wb.wbs_ack_o}, 32'h0);
        check("rst_dat", wb.wbs_dat_o, 32'h0);
        check("rst_irq", {31'h0, rx_irq}, 32'h0);
        rx_vld = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        rd_chk("ctrl0", RegCtrl, 32'h0);
        check("ctrl_lat", lat, 32'd1);
        @(negedge clk);
        check("one_ack", {31'h0, wb.wbs_ack_o}, 32'h0);
        rd_chk("status0", RegStatus, 32'h0);
        rd_chk("len0", RegLen, 32'h0);
        rd_chk("data_empty", RegData, 32'h0);
        wr(RegCtrl, 32'h3);
        rd_chk("ctrl3", RegCtrl, 32'h3);

        // 60-byte frame, read back in order
        send_frame(60, 8'h10, -1, 0);
        repeat (2) @(negedge clk);
        rd_chk("st_1frame", RegStatus, 32'h1);
        rd_chk("len60", RegLen, exp_len(60));
        check("irq_on", {31'h0, rx_irq}, 32'h1);
        for (int i = 0; i < 60; i++) rd_chk("data60", RegData, exp_byte(8'h10, i, 60));
        rd_chk("data_past", RegData, 32'h0);
        wr(RegPop, 32'h0);
        rd_chk("st_popped", RegStatus, 32'h0);
        rd_chk("len_popped", RegLen, 32'h0);
        repeat (2) @(negedge clk);
        check("irq_off", {31'h0, rx_irq}, 32'h0);

        // DATA read held off by a continuous 5-byte burst
        send_frame(8, 8'h40, -1, 60);
        @(negedge clk);
        wb.wbs_stb_i = 1'b1; wb.wbs_cyc_i = 1'b1; wb.wbs_we_i = 1'b0;
        wb.wbs_adr_i = {27'h0, RegData};
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                @(negedge clk);
                check("busy_noack", {31'h0, wb.wbs_ack_o}, 32'h0);
            end
            rx_vld = 1'b1; rx_data = 8'h80 + 8'(k); rx_last = (k == 4);
        end
        @(negedge clk);
        check("busy_noack", {31'h0, wb.wbs_ack_o}, 32'h0);
        rx_vld = 1'b0; rx_last = 1'b0;
        got = 1'b0; rdat = '0;
        for (int k = 0; k < 16 && !got; k++) begin
            @(negedge clk);
            if (wb.wbs_ack_o) begin got = 1'b1; rdat = wb.wbs_dat_o; end
        end
        wb.wbs_stb_i = 1'b0; wb.wbs_cyc_i = 1'b0;
        check("dly_ack", {31'h0, got}, 32'h1);
        check("dly_data", rdat, 32'h40);
        rd_chk("st_2frames", RegStatus, 32'h2);
        wr(RegPop, 32'h0);
        rd_chk("len5", RegLen, exp_len(5));
        for (int i = 0; i < 5; i++) rd_chk("burst_data", RegData, exp_byte(8'h80, i, 5));
        wr(RegPop, 32'h0);

        // rx_err on byte 10 drops the frame; the next frame reuses its start address
        send_frame(20, 8'h20, 9, 73);
        rd_chk("st_err", RegStatus, 32'h100);
        send_frame(20, 8'h30, -1, 73);
        rd_chk("st_after_err", RegStatus, 32'h101);
        wr(RegStatus, 32'h100);
        rd_chk("st_w1c", RegStatus, 32'h1);
        rd_chk("len20", RegLen, exp_len(20));
        rd_chk("data_reuse", RegData, 32'h30);
        wr(RegPop, 32'h0);

        // five frames without POP: fifth is dropped
        for (int k = 0; k < 4; k++) send_frame(100, 8'(k * 16), -1, 93 + k * 100);
        send_frame(100, 8'h70, -1, -2);
        rd_chk("st_fifo_full", RegStatus, 32'h104);
        wr(RegStatus, 32'h100);
        rd_chk("st_full_w1c", RegStatus, 32'h4);
        rd_chk("len100", RegLen, exp_len(100));
        rd_chk("data_f0", RegData, 32'h0);
        for (int k = 0; k < 3; k++) wr(RegPop, 32'h0);
        rd_chk("st_one_left", RegStatus, 32'h1);

        // push and pop in the same cycle
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            rx_vld = 1'b1; rx_data = 8'h50 + 8'(k); rx_last = 1'b0;
        end
        @(negedge clk);
        rx_data = 8'h52; rx_last = 1'b1;
        wb.wbs_stb_i = 1'b1; wb.wbs_cyc_i = 1'b1; wb.wbs_we_i = 1'b1;
        wb.wbs_adr_i = {27'h0, RegPop};
        @(negedge clk);
        rx_vld = 1'b0; rx_last = 1'b0;
        check("pp_ack", {31'h0, wb.wbs_ack_o}, 32'h1);
        wb.wbs_stb_i = 1'b0; wb.wbs_cyc_i = 1'b0; wb.wbs_we_i = 1'b0;
        rd_chk("st_pushpop", RegStatus, 32'h1);
        rd_chk("len3", RegLen, exp_len(3));
        rd_chk("data_pp", RegData, exp_byte(8'h50, 0, 3));
        wr(RegPop, 32'h0);
        rd_chk("st_pp_empty", RegStatus, 32'h0);

        // ring wrap and full-ring drop
        send_frame(500, 8'hA0, -1, 496);
        send_frame(200, 8'h33, -1, 996);
        rd_chk("len500", RegLen, exp_len(500));
        wr(RegPop, 32'h0);
        rd_chk("len200", RegLen, exp_len(200));
        for (int i = 0; i < 200; i++) rd_chk("wrap_data", RegData, exp_byte(8'h33, i, 200));
        send_frame(824, 8'h11, -1, 172);
        send_frame(5, 8'h99, -1, -2);
        rd_chk("st_ring_full", RegStatus, 32'h102);
        wr(RegPop, 32'h0);
        rd_chk("len824", RegLen, exp_len(824));
        rd_chk("data_c0", RegData, 32'h11);
        rd_chk("data_c1", RegData, 32'h12);

        // reset asserted while the read FSM waits on SRAM data
        @(negedge clk);
        wb.wbs_stb_i = 1'b1; wb.wbs_cyc_i = 1'b1; wb.wbs_we_i = 1'b0;
        wb.wbs_adr_i = {27'h0, RegData};
        repeat (2) @(negedge clk);
        check("irq_pre_rst", {31'h0, rx_irq}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("mrst_ack", {31'h0, wb.wbs_ack_o}, 32'h0);
        check("mrst_dat", wb.wbs_dat_o, 32'h0);
        check("mrst_irq", {31'h0, rx_irq}, 32'h0);
        check("mrst_csb", {31'h0, mem_csb}, 32'h1);
        check("mrst_web", {31'h0, mem_web}, 32'h1);
        check("mrst_addr", {22'h0, mem_addr}, 32'h0);
        @(negedge clk);
        check("mrst_noack", {31'h0, wb.wbs_ack_o}, 32'h0);
        wb.wbs_stb_i = 1'b0; wb.wbs_cyc_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_noack", {31'h0, wb.wbs_ack_o}, 32'h0);
        rd_chk("post_ctrl", RegCtrl, 32'h0);
        rd_chk("post_status", RegStatus, 32'h0);
        rd_chk("post_len", RegLen, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
